// File: rtl/cordic_sincos.sv
// Pipelined rotation-mode CORDIC: 3.13 unsigned-radian phase in, Q2.14 cos/sin out, 20-cycle latency.
// Optional NCO mode (phase_i as increment into an internal accumulator): define CORDIC_SINCOS_PHASE_ACC_EN.
module cordic_sincos #(
    parameter int OW      = 16,
    parameter int NSTAGES = 18,
    parameter int WW      = 21,
    parameter int PW      = 26
) (
    input  logic                 clk_i,
    input  logic                 nrst_i,
    input  logic                 valid_i,
    input  logic [15:0]          phase_i,
    output logic signed [OW-1:0] cos_o,
    output logic signed [OW-1:0] sin_o,
    output logic                 sincos_valid_o
);

    localparam logic [16:0]          TWO_PI   = 17'd51472;
    localparam logic signed [WW-1:0] X_INIT   = WW'(318375);
    localparam logic signed [WW-1:0] RND_HALF = WW'(16);
    localparam logic signed [WW-1:0] SAT_POS  = WW'(16384);
    localparam logic signed [WW-1:0] SAT_NEG  = WW'(-16384);

    function automatic logic signed [PW-1:0] atan_lut(input int i);
        logic signed [PW-1:0] a;
        case (i)
            0:       a = PW'(3294199);
            1:       a = PW'(1944679);
            2:       a = PW'(1027515);
            3:       a = PW'(521583);
            4:       a = PW'(261803);
            5:       a = PW'(131029);
            6:       a = PW'(65531);
            7:       a = PW'(32767);
            8:       a = PW'(16384);
            9:       a = PW'(8192);
            10:      a = PW'(4096);
            11:      a = PW'(2048);
            12:      a = PW'(1024);
            13:      a = PW'(512);
            14:      a = PW'(256);
            15:      a = PW'(128);
            16:      a = PW'(64);
            17:      a = PW'(32);
            default: a = '0;
        endcase
        return a;
    endfunction

    function automatic logic signed [OW-1:0] rnd_sat(input logic signed [WW-1:0] v);
        logic signed [WW-1:0] t;
        logic signed [OW-1:0] r;
        t = (v + RND_HALF) >>> 5;
        if (t > SAT_POS)
            r = SAT_POS[OW-1:0];
        else if (t < SAT_NEG)
            r = SAT_NEG[OW-1:0];
        else
            r = t[OW-1:0];
        return r;
    endfunction

    logic [15:0] ph_src;

`ifdef CORDIC_SINCOS_PHASE_ACC_EN
    logic [15:0] acc;
    logic [16:0] acc_sum;

    assign acc_sum = {1'b0, acc} + {1'b0, phase_i};

    // Stage P sees the pre-update value, so the first output is phase 0.
    always_ff @(posedge clk_i) begin
        if (!nrst_i)
            acc <= '0;
        else if (valid_i)
            acc <= (acc_sum >= TWO_PI) ? 16'(acc_sum - TWO_PI) : acc_sum[15:0];
    end

    assign ph_src = acc;
`else
    assign ph_src = phase_i;
`endif

    logic [16:0]        p_wrap;
    logic [1:0]         k_pre;
    logic signed [17:0] r_pre;

    // Fold phase into one of four quadrants so the residual stays within +/-pi/4.
    always_comb begin
        p_wrap = ({1'b0, ph_src} >= TWO_PI) ? ({1'b0, ph_src} - TWO_PI) : {1'b0, ph_src};
        k_pre  = 2'd0;
        r_pre  = $signed({1'b0, p_wrap});
        if (p_wrap < 17'd6434) begin
            k_pre = 2'd0;
            r_pre = $signed({1'b0, p_wrap});
        end else if (p_wrap < 17'd19302) begin
            k_pre = 2'd1;
            r_pre = $signed({1'b0, p_wrap}) - 18'sd12868;
        end else if (p_wrap < 17'd32170) begin
            k_pre = 2'd2;
            r_pre = $signed({1'b0, p_wrap}) - 18'sd25736;
        end else if (p_wrap < 17'd45037) begin
            k_pre = 2'd3;
            r_pre = $signed({1'b0, p_wrap}) - 18'sd38604;
        end else begin
            k_pre = 2'd0;
            r_pre = $signed({1'b0, p_wrap}) - 18'sd51472;
        end
    end

    logic signed [WW-1:0] x_q [0:NSTAGES];
    logic signed [WW-1:0] y_q [0:NSTAGES];
    logic signed [PW-1:0] z_q [0:NSTAGES];
    logic [1:0]           k_q [0:NSTAGES];
    logic [NSTAGES+1:0]   vld_sr;

    logic signed [WW-1:0] c_pre;
    logic signed [WW-1:0] s_pre;

    always_comb begin
        c_pre = x_q[NSTAGES];
        s_pre = y_q[NSTAGES];
        case (k_q[NSTAGES])
            2'd1:    begin c_pre = -y_q[NSTAGES]; s_pre =  x_q[NSTAGES]; end
            2'd2:    begin c_pre = -x_q[NSTAGES]; s_pre = -y_q[NSTAGES]; end
            2'd3:    begin c_pre =  y_q[NSTAGES]; s_pre = -x_q[NSTAGES]; end
            default: begin c_pre =  x_q[NSTAGES]; s_pre =  y_q[NSTAGES]; end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!nrst_i) begin
            for (int i = 0; i <= NSTAGES; i++) begin
                x_q[i] <= '0;
                y_q[i] <= '0;
                z_q[i] <= '0;
                k_q[i] <= '0;
            end
            vld_sr <= '0;
            cos_o  <= '0;
            sin_o  <= '0;
        end else begin
            x_q[0] <= X_INIT;
            y_q[0] <= '0;
            z_q[0] <= {{(PW-18){r_pre[17]}}, r_pre} << 9;
            k_q[0] <= k_pre;
            for (int i = 0; i < NSTAGES; i++) begin
                if (!z_q[i][PW-1]) begin
                    x_q[i+1] <= x_q[i] - (y_q[i] >>> i);
                    y_q[i+1] <= y_q[i] + (x_q[i] >>> i);
                    z_q[i+1] <= z_q[i] - atan_lut(i);
                end else begin
                    x_q[i+1] <= x_q[i] + (y_q[i] >>> i);
                    y_q[i+1] <= y_q[i] - (x_q[i] >>> i);
                    z_q[i+1] <= z_q[i] + atan_lut(i);
                end
                k_q[i+1] <= k_q[i];
            end
            vld_sr <= {vld_sr[NSTAGES:0], valid_i};
            cos_o  <= rnd_sat(c_pre);
            sin_o  <= rnd_sat(s_pre);
        end
    end

    assign sincos_valid_o = vld_sr[NSTAGES+1];

endmodule

// File: tb/tb_cordic_sincos.sv
// Directed bench for cordic_sincos: quadrant/octant/wrap points, reset mid-stream, full phase sweep.
// NCO-mode checks run instead when CORDIC_SINCOS_PHASE_ACC_EN is defined.
module tb_cordic_sincos;

    logic               clk_i = 1'b0;
    logic               nrst_i;
    logic               valid_i;
    logic [15:0]        phase_i;
    logic signed [15:0] cos_o;
    logic signed [15:0] sin_o;
    logic               sincos_valid_o;

    always #5 clk_i = ~clk_i;

    cordic_sincos dut (
        .clk_i          (clk_i),
        .nrst_i         (nrst_i),
        .valid_i        (valid_i),
        .phase_i        (phase_i),
        .cos_o          (cos_o),
        .sin_o          (sin_o),
        .sincos_valid_o (sincos_valid_o)
    );

    typedef struct {
        int cyc;
        int c;
        int s;
        int tol;
    } exp_t;

    exp_t expq[$];
    exp_t e_mon;
    int   got_c[$];
    int   got_s[$];
    int   cyc    = 0;
    int   n_chk  = 0;
    int   n_err  = 0;
    int   npulse = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic chk(input string tag, input longint got, input longint exp, input longint tol);
        n_chk++;
        if (got > exp + tol || got < exp - tol) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0d want %0d (tol %0d)", tag, cyc, got, exp, tol);
        end
    endtask

    function automatic int wrapp(input int ph);
        return (ph >= 51472) ? ph - 51472 : ph;
    endfunction

    function automatic int mdl_c(input int ph);
        return int'(16384.0 * $cos(real'(wrapp(ph)) / 8192.0));
    endfunction

    function automatic int mdl_s(input int ph);
        return int'(16384.0 * $sin(real'(wrapp(ph)) / 8192.0));
    endfunction

    always @(negedge clk_i) begin
        if (sincos_valid_o === 1'b1) begin
            npulse++;
            got_c.push_back(int'(cos_o));
            got_s.push_back(int'(sin_o));
            chk("mag", longint'(cos_o) * longint'(cos_o) + longint'(sin_o) * longint'(sin_o),
                268435456, 268435);
            if (expq.size() == 0) begin
                chk("spurious", 1, 0, 0);
            end else begin
                e_mon = expq.pop_front();
                chk("latency", cyc, e_mon.cyc, 0);
                chk("cos", cos_o, e_mon.c, e_mon.tol);
                chk("sin", sin_o, e_mon.s, e_mon.tol);
            end
        end
    end

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send(input int ph, input int ec, input int es, input int tol);
        valid_i = 1'b1;
        phase_i = 16'(ph);
        expq.push_back('{cyc + 20, ec, es, tol});
        step();
    endtask

    task automatic drain();
        valid_i = 1'b0;
        for (int i = 0; i < 40 && expq.size() > 0; i++) step();
        chk("drain", expq.size(), 0, 0);
    endtask

`ifdef CORDIC_SINCOS_PHASE_ACC_EN
    int acc_m;
    int dmax;
`endif

    initial begin
        nrst_i  = 1'b0;
        valid_i = 1'b0;
        phase_i = '0;
        repeat (3) step();
        chk("rst_vld", sincos_valid_o, 0, 0);
        chk("rst_cos", cos_o, 0, 0);
        chk("rst_sin", sin_o, 0, 0);
        nrst_i = 1'b1;
        step();

`ifdef CORDIC_SINCOS_PHASE_ACC_EN
        acc_m = 0;
        got_c.delete();
        got_s.delete();
        send(1287, 16384, 0, 3);
        acc_m = 1287;
        for (int i = 1; i < 80; i++) begin
            send(1287, mdl_c(acc_m), mdl_s(acc_m), 3);
            acc_m = acc_m + 1287;
            if (acc_m >= 51472) acc_m = acc_m - 51472;
        end
        drain();
        chk("nco_period_c", got_c[40], got_c[0], 20);
        chk("nco_period_s", got_s[40], got_s[0], 20);
        dmax = 0;
        for (int i = 1; i < got_c.size(); i++) begin
            if (got_c[i] - got_c[i-1] > dmax) dmax = got_c[i] - got_c[i-1];
            if (got_c[i-1] - got_c[i] > dmax) dmax = got_c[i-1] - got_c[i];
            if (got_s[i] - got_s[i-1] > dmax) dmax = got_s[i] - got_s[i-1];
            if (got_s[i-1] - got_s[i] > dmax) dmax = got_s[i-1] - got_s[i];
        end
        chk("nco_step", dmax, 1300, 1300);
`else
        // Single sample: exactly one output pulse.
        npulse = 0;
        send(0, 16384, 0, 3);
        drain();
        repeat (5) step();
        chk("pulses", npulse, 1, 0);

        send(12868, 0, 16384, 3);
        send(25736, -16384, 0, 3);
        send(38604, 0, -16384, 3);
        drain();

        send(6433, 11585, 11585, 3);
        send(6434, 11585, 11585, 3);
        drain();

        got_c.delete();
        got_s.delete();
        send(51472, 16384, 0, 3);
        send(14063, mdl_c(14063), mdl_s(14063), 3);
        send(65535, mdl_c(14063), mdl_s(14063), 3);
        drain();
        chk("wrap_c", got_c[2], got_c[1], 1);
        chk("wrap_s", got_s[2], got_s[1], 1);

        // Reset lands on sample 5 together with valid_i; nothing issued before it may emerge.
        npulse = 0;
        for (int i = 0; i < 10; i++) begin
            if (i == 5) begin
                nrst_i  = 1'b0;
                valid_i = 1'b1;
                phase_i = 16'd20000;
                step();
                expq.delete();
                chk("midrst_vld", sincos_valid_o, 0, 0);
                chk("midrst_cos", cos_o, 0, 0);
                chk("midrst_sin", sin_o, 0, 0);
                nrst_i = 1'b1;
            end else begin
                send(i * 4000, mdl_c(i * 4000), mdl_s(i * 4000), 3);
            end
        end
        drain();
        repeat (5) step();
        chk("midrst_pulses", npulse, 4, 0);

        npulse = 0;
        for (int p = 0; p < 51472; p++) send(p, mdl_c(p), mdl_s(p), 3);
        drain();
        chk("sweep_pulses", npulse, 51472, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/cordic_sincos.md
Name: cordic_sincos

Overview:
- Pipelined CORDIC block in rotation mode. It converts an unsigned phase word into signed cosine/sine samples.
- It is the inverse partner of the arctangent phase extractor. It uses the same 3.13 unsigned-radian phase format and the same 16-bit signed sample width.
- It sits in the timing core as the reference/NCO waveform generator. Its outputs feed the phase detector and the DAC path.
- Fully pipelined: one sample per clock, fixed latency.

Parameters:
- OW, 16: output sample width (signed).
- NSTAGES, 18: number of CORDIC micro-rotation stages (i = 0..NSTAGES-1).
- WW, 21: working x/y width, signed.
- PW, 26: residual-angle width, signed, 4.22 radians.
- Only the defaults are supported and verified.

Ports:
- clk_i  in  1  clock, rising edge.
- nrst_i  in  1  reset, synchronous, active-low.
- valid_i  in  1  phase_i is valid this cycle.
- phase_i  in  16  unsigned phase, 3.13 radians; 2π = 51472.
- cos_o  out  16  signed cosine, Q2.14 (1.0 = 16384).
- sin_o  out  16  signed sine, Q2.14.
- sincos_valid_o  out  1  cos_o/sin_o valid this cycle.

Behaviour:
- Reset (nrst_i low at a clk_i edge):
  - All pipeline registers and the valid shift register clear to 0.
  - cos_o = 0, sin_o = 0, sincos_valid_o = 0 from the next edge.
  - In-flight samples are discarded and never emerge.
- Pipeline:
  - Free-running; every stage registers every cycle regardless of valid_i.
  - Valid travels in a NSTAGES+2 bit shift register.
  - Latency = NSTAGES+2 = 20 cycles from the valid_i edge to sincos_valid_o. Throughput is 1 sample/cycle, no backpressure.
  - Sample order is preserved.
  - cos_o/sin_o are registered. When sincos_valid_o = 0 they hold whatever the pipeline carries (don't-care to consumers).
- Stage P (pre-rotation):
  - Wrap: if phase_i ≥ 51472, use p = phase_i − 51472; otherwise p = phase_i.
  - Quadrant k: 0 if p < 6434; 1 if p < 19302; 2 if p < 32170; 3 if p < 45037; else 0 with p − 51472.
  - Residual z0 = (p − k·12868) sign-extended to PW, then shifted left by 9 (3.13 → 4.22). Result lies in ±π/4.
  - x0 = round(2^19/K) = 318375, where K = 1.646760258 (gain pre-compensation). y0 = 0.
  - k is carried alongside the data.
- Stage i, i = 0..17:
  - If z ≥ 0: x' = x − (y>>>i), y' = y + (x>>>i), z' = z − A[i].
  - Otherwise: x' = x + (y>>>i), y' = y − (x>>>i), z' = z + A[i].
  - Shifts are arithmetic.
  - A[i] = round(atan(2^−i)·2^22).
  - All arithmetic is in WW/PW bits and does not overflow (|x|, |y| < 2^20).
- Stage Q (post-rotation):
  - k = 0: (c, s) = (x, y).
  - k = 1: (c, s) = (−y, x).
  - k = 2: (c, s) = (−x, −y).
  - k = 3: (c, s) = (y, −x).
- Output rounding:
  - Drop 5 LSBs, round half up: (v + 16) >>> 5.
  - Saturate to [−16384, +16384].
- Accuracy: |error| ≤ 3 LSB versus round(16384·cos/sin(phase)) over the full input range.
- Simultaneous reset and valid_i: reset wins; the sample is dropped.

Optional Feature:
- Macro: CORDIC_SINCOS_PHASE_ACC_EN.
- Defined (NCO mode):
  - phase_i is interpreted as a phase increment.
  - An internal 16-bit accumulator acc updates on each valid_i: acc ← (acc + phase_i) mod 51472, with a single conditional subtract. Increments are restricted to < 51472.
  - Stage P uses the pre-update acc value, so the first output is phase 0.
  - acc resets to 0.
  - Latency is unchanged.
- Undefined: phase_i is used directly as described above; no accumulator exists.

Test Plan:
- Quadrant points: reset, then phase_i = 0 with valid_i for one cycle.
  - sincos_valid_o pulses exactly once, 20 cycles later, with cos = 16384±3 and sin = 0±3.
  - phase 12868 → (0, 16384); 25736 → (−16384, 0); 38604 → (0, −16384); all ±3.
- Octant boundary: phase 6433 and 6434 on back-to-back cycles.
  - Both give cos ≈ sin ≈ 11585±3.
  - Outputs appear on consecutive cycles, continuous across the quadrant switch.
- Wrap: phase 51472 → same result as 0. Phase 65535 → same result as 14063 (±1 LSB).
- Streaming sweep: phase 0..51471 step 1 with valid_i held high.
  - sincos_valid_o stays high continuously after 20 cycles.
  - Every sample is within ±3 LSB of the model.
  - c² + s² stays within 16384² ± 0.1%.
- Reset mid-stream: drive 10 samples, pull nrst_i low for 1 cycle at sample 5.
  - From the next edge: valid_o = 0, cos_o = sin_o = 0.
  - No pre-reset sample ever emerges.
  - New input after reset emerges after exactly 20 cycles.
- NCO (macro defined): phase_i = 1287 with valid_i held high.
  - First output is (16384, 0).
  - Output is periodic with period ≈ 40 samples.
  - acc wraps without a discontinuity larger than one step.
